music_sequencer: RTL and testbench
==================================

// Module: music_sequencer
// PURPOSE
// Tone sequencer between the game FSM and the audio pin/buzzer. It consumes the FSM's song select (music_ind) and start request (play_music).
// It plays the selected fixed melody as a 1-bit square wave.
// At the end of the melody it returns a one-cycle o_music_stop pulse, which drives the FSM's i_music_stop input (GAME->MODET, KILL->DIE).
// PARAMETERS
// NOTE_CYC  6_250_000  cycles of sounding per note (0.25 s @ 25 MHz); must be >= 1
// GAP_CYC   1_250_000  silent cycles after every note; 0 = no gap (GAP state skipped)
// PORTS
// i_clk_25      in   1   25 MHz pixel/system clock
// i_rst_n       in   1   async active-low reset
// i_music_ind   in   2   song select: 0 game, 1 kill, 2 win, 3 die
// i_play        in   1   start request (level, may stay high for many cycles); rising edge starts a song
// o_audio       out  1   square-wave tone to buzzer/codec
// o_playing     out  1   high in PLAY or GAP
// o_music_stop  out  1   1-cycle pulse: song completed
// o_note_idx    out  3   index of current note within song
// BEHAVIOUR
// - Reset (async, any time incl. mid-song): state IDLE, all outputs 0, play_d 0, all counters 0.
// - Edge detect: play_d <= i_play each cycle; start = i_play & ~play_d. Only a rising edge starts a song; a held level never retriggers.
// - On start (any state): latch song <= i_music_ind, note_idx <= 0, dur_cnt <= 0, tone_cnt <= 0, audio <= 0, state <= PLAY.
//   Start has priority over every other event, including final-note completion (no stop pulse then).
// - FSM IDLE/PLAY/GAP:
//   PLAY: dur_cnt counts 0..NOTE_CYC-1. At NOTE_CYC-1: go to GAP (if GAP_CYC>0) or advance; audio <= 0.
//   GAP: dur_cnt counts 0..GAP_CYC-1, audio held 0. At end: advance.
//   advance: if note_idx == LEN[song]-1, state <= IDLE and o_music_stop <= 1 for exactly one cycle.
//            Otherwise note_idx++, state <= PLAY, dur_cnt/tone_cnt/audio cleared.
// - Tone: HALF[code] half-period (16-bit tone_cnt). In PLAY with code!=0, tone_cnt counts 0..HALF-1.
//   At HALF-1 it wraps to 0 and audio toggles. Each note starts with audio low. Code 0 = rest (audio 0).
// - HALF (cycles): 1 C5 23889, 2 D5 21282, 3 E5 18960, 4 F5 17896, 5 G5 15944, 6 A5 14205, 7 B5 12655, 8 C6 11945.
// - Songs (note codes; LEN): 0 = 3,5,5,6,5,3,5,0 (8); 1 = 8,0,8,0 (4); 2 = 1,3,5,8,5,8 (6); 3 = 5,4,3,1 (4).
//   Implemented as a combinational ROM indexed {song, note_idx}.
// - Timing: rising edge sampled at cycle t gives o_playing=1 and note_idx=0 from t+1.
//   o_music_stop is high only in cycle t+1+LEN*(NOTE_CYC+GAP_CYC); o_playing is 0 in that same cycle.
// - i_music_ind changes while playing are ignored until the next rising edge.
// - dur_cnt width: $clog2(max(NOTE_CYC,GAP_CYC))+1; no counter ever exceeds its terminal value.
// TESTING
// 1. Use NOTE_CYC=60000, GAP_CYC=100. Reset, then hold i_play high 255 cycles with ind=1.
//    -> o_playing high 4*60100 cycles.
//    -> o_audio toggles every 11945 cycles in notes 0 and 2, stays 0 in notes 1 and 3.
//    -> single stop pulse; no retrigger while i_play stays high.
// 2. ind=0 with GAP_CYC=0 -> o_note_idx steps 0..7 every 60000 cycles; first toggle at cycle 18960 of note 0.
//    -> stop pulse exactly 480000 cycles after o_playing rises.
// 3. Second rising edge with ind=3 during note 2 of song 2 -> song restarts at note_idx 0 on the next cycle.
//    -> first note half-period 15944; no stop pulse from the aborted song.
// 4. Rising edge in the same cycle as the final GAP end of song 1 -> no o_music_stop, PLAY note 0 of the new song.
// 5. Assert i_rst_n low mid-note -> o_audio, o_playing, o_music_stop, o_note_idx all 0 immediately (async).
//    -> stays IDLE after release with i_play held high.
// 6. ind=2 with GAP_CYC=100 -> o_audio = 0 throughout every GAP.
//    -> every note begins with o_audio=0 and toggles first at HALF cycles.

Source files
------------

// File: rtl/music_sequencer.sv
// music_sequencer
// Plays one of four fixed melodies as a 1-bit square wave. A rising edge on
// i_play latches the song select and starts the song. When the last note
// (and its trailing gap) completes, the block pulses o_music_stop for one
// cycle and returns to idle.
//
// Ports:
//   i_clk_25     - system clock (25 MHz)
//   i_rst_n      - asynchronous active-low reset
//   i_music_ind  - song select (0 game, 1 kill, 2 win, 3 die), latched at start
//   i_play       - start request level; only its rising edge starts a song
//   o_audio      - square-wave tone output
//   o_playing    - high while a note or an inter-note gap is in progress
//   o_music_stop - one-cycle pulse when a song runs to completion
//   o_note_idx   - index of the current note within the song
module music_sequencer #(
  parameter int unsigned NOTE_CYC = 6_250_000,
  parameter int unsigned GAP_CYC  = 1_250_000
) (
  input  logic       i_clk_25,
  input  logic       i_rst_n,
  input  logic [1:0] i_music_ind,
  input  logic       i_play,
  output logic       o_audio,
  output logic       o_playing,
  output logic       o_music_stop,
  output logic [2:0] o_note_idx
);

  localparam int unsigned MAX_CYC = (NOTE_CYC > GAP_CYC) ? NOTE_CYC : GAP_CYC;
  localparam int DUR_W = $clog2(MAX_CYC) + 1;
  localparam logic [DUR_W-1:0] NOTE_LAST = DUR_W'(NOTE_CYC - 1);
  localparam logic [DUR_W-1:0] GAP_LAST  = DUR_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
  localparam logic HAS_GAP = (GAP_CYC > 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  // Melody ROM indexed by {song, note}; code 0 is a rest.
  function automatic logic [3:0] note_code(input logic [1:0] song, input logic [2:0] idx);
    case ({song, idx})
      5'd0, 5'd5:               note_code = 4'd3;
      5'd1, 5'd2, 5'd4, 5'd6:   note_code = 4'd5;
      5'd3:                     note_code = 4'd6;
      5'd8, 5'd10:              note_code = 4'd8;
      5'd16:                    note_code = 4'd1;
      5'd17:                    note_code = 4'd3;
      5'd18, 5'd20:             note_code = 4'd5;
      5'd19, 5'd21:             note_code = 4'd8;
      5'd24:                    note_code = 4'd5;
      5'd25:                    note_code = 4'd4;
      5'd26:                    note_code = 4'd3;
      5'd27:                    note_code = 4'd1;
      default:                  note_code = 4'd0;
    endcase
  endfunction

  // Index of the final note of each song (length - 1).
  function automatic logic [2:0] song_last(input logic [1:0] song);
    case (song)
      2'd0:    song_last = 3'd7;
      2'd1:    song_last = 3'd3;
      2'd2:    song_last = 3'd5;
      2'd3:    song_last = 3'd3;
      default: song_last = 3'd0;
    endcase
  endfunction

  // Tone half-period in clock cycles for each note code.
  function automatic logic [15:0] half_cyc(input logic [3:0] code);
    case (code)
      4'd1:    half_cyc = 16'd23889;
      4'd2:    half_cyc = 16'd21282;
      4'd3:    half_cyc = 16'd18960;
      4'd4:    half_cyc = 16'd17896;
      4'd5:    half_cyc = 16'd15944;
      4'd6:    half_cyc = 16'd14205;
      4'd7:    half_cyc = 16'd12655;
      4'd8:    half_cyc = 16'd11945;
      default: half_cyc = 16'd1;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic             play_prev_q, play_prev_d;
  logic [1:0]       song_q, song_d;
  logic [2:0]       note_q, note_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [15:0]      tone_q, tone_d;
  logic             audio_q, audio_d;
  logic             stop_q, stop_d;

  logic       start_s;
  logic       note_end_s;
  logic       gap_end_s;
  logic       last_note_s;
  logic [3:0] code_s;

  assign start_s     = i_play & ~play_prev_q;
  assign note_end_s  = (state_q == S_PLAY) && (dur_q == NOTE_LAST);
  assign gap_end_s   = (state_q == S_GAP) && (dur_q == GAP_LAST);
  assign last_note_s = (note_q == song_last(song_q));
  assign code_s      = note_code(song_q, note_q);

  // State register.
  always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a new start overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (start_s) begin
      state_d = S_PLAY;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_PLAY: begin
          if (note_end_s) begin
            if (HAS_GAP) begin
              state_d = S_GAP;
            end else begin
              state_d = last_note_s ? S_IDLE : S_PLAY;
            end
          end else begin
            state_d = S_PLAY;
          end
        end
        S_GAP: begin
          if (gap_end_s) begin
            state_d = last_note_s ? S_IDLE : S_PLAY;
          end else begin
            state_d = S_GAP;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath next values: counters, tone generator, note index, stop pulse.
  always_comb begin
    play_prev_d = i_play;
    song_d      = song_q;
    note_d      = note_q;
    dur_d       = dur_q;
    tone_d      = tone_q;
    audio_d     = audio_q;
    stop_d      = 1'b0;
    if (start_s) begin
      song_d  = i_music_ind;
      note_d  = 3'd0;
      dur_d   = '0;
      tone_d  = 16'd0;
      audio_d = 1'b0;
    end else begin
      case (state_q)
        S_PLAY: begin
          if (note_end_s) begin
            dur_d   = '0;
            tone_d  = 16'd0;
            audio_d = 1'b0;
            // Without a gap the note boundary is also the advance point.
            if (!HAS_GAP) begin
              if (last_note_s) begin
                stop_d = 1'b1;
              end else begin
                note_d = note_q + 3'd1;
              end
            end else begin
              note_d = note_q;
            end
          end else begin
            dur_d = dur_q + DUR_W'(1);
            if (code_s == 4'd0) begin
              tone_d  = 16'd0;
              audio_d = 1'b0;
            end else if (tone_q == (half_cyc(code_s) - 16'd1)) begin
              tone_d  = 16'd0;
              audio_d = ~audio_q;
            end else begin
              tone_d = tone_q + 16'd1;
            end
          end
        end
        S_GAP: begin
          audio_d = 1'b0;
          if (gap_end_s) begin
            dur_d  = '0;
            tone_d = 16'd0;
            if (last_note_s) begin
              stop_d = 1'b1;
            end else begin
              note_d = note_q + 3'd1;
            end
          end else begin
            dur_d = dur_q + DUR_W'(1);
          end
        end
        S_IDLE: begin
          audio_d = 1'b0;
        end
        default: begin
          dur_d   = '0;
          tone_d  = 16'd0;
          audio_d = 1'b0;
        end
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      play_prev_q <= 1'b0;
      song_q      <= 2'd0;
      note_q      <= 3'd0;
      dur_q       <= '0;
      tone_q      <= 16'd0;
      audio_q     <= 1'b0;
      stop_q      <= 1'b0;
    end else begin
      play_prev_q <= play_prev_d;
      song_q      <= song_d;
      note_q      <= note_d;
      dur_q       <= dur_d;
      tone_q      <= tone_d;
      audio_q     <= audio_d;
      stop_q      <= stop_d;
    end
  end

  assign o_audio      = audio_q;
  assign o_playing    = (state_q != S_IDLE);
  assign o_music_stop = stop_q;
  assign o_note_idx   = note_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Bench for music_sequencer: two instances share one clock. The "fast" one
// has very short notes (sequencing, restart, stop pulse, reset); the "tone"
// one has notes long enough to observe the square-wave half-periods.
// A timeline model predicts every output from the cycle count since the
// last rising edge of i_play.
module tb_music_sequencer;

  logic       clk;
  logic [1:0] rst_n_v;
  logic [1:0] play_v;
  logic [1:0] ind_v [2];
  logic [1:0] audio_v, playing_v, stop_v;
  logic [2:0] idx_v [2];

  int unsigned note_cyc [2] = '{50, 24000};
  int unsigned gap_cyc  [2] = '{10, 0};

  music_sequencer #(.NOTE_CYC(50), .GAP_CYC(10)) u_fast (
    .i_clk_25(clk), .i_rst_n(rst_n_v[0]), .i_music_ind(ind_v[0]), .i_play(play_v[0]),
    .o_audio(audio_v[0]), .o_playing(playing_v[0]), .o_music_stop(stop_v[0]),
    .o_note_idx(idx_v[0]));

  music_sequencer #(.NOTE_CYC(24000), .GAP_CYC(0)) u_tone (
    .i_clk_25(clk), .i_rst_n(rst_n_v[1]), .i_music_ind(ind_v[1]), .i_play(play_v[1]),
    .o_audio(audio_v[1]), .o_playing(playing_v[1]), .o_music_stop(stop_v[1]),
    .o_note_idx(idx_v[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int song_len [4] = '{8, 4, 6, 4};
  int song_codes [4][8] = '{'{3, 5, 5, 6, 5, 3, 5, 0},
                            '{8, 0, 8, 0, 0, 0, 0, 0},
                            '{1, 3, 5, 8, 5, 8, 0, 0},
                            '{5, 4, 3, 1, 0, 0, 0, 0}};
  int half_tab [9] = '{0, 23889, 21282, 18960, 17896, 15944, 14205, 12655, 11945};

  // Model state per instance.
  bit m_active [2];
  bit m_prev   [2];
  int m_song   [2];
  int m_k      [2];
  int m_idle_idx [2];

  int total;
  int passed;

  task automatic model_reset(input int d);
    m_active[d]   = 1'b0;
    m_prev[d]     = 1'b0;
    m_k[d]        = 0;
    m_idle_idx[d] = 0;
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_tick(input int d);
    int per;
    if (!rst_n_v[d]) begin
      model_reset(d);
    end else begin
      if (play_v[d] && !m_prev[d]) begin
        m_active[d] = 1'b1;
        m_song[d]   = int'(ind_v[d]);
        m_k[d]      = 0;
      end else if (m_active[d]) begin
        per = int'(note_cyc[d] + gap_cyc[d]);
        m_k[d] = m_k[d] + 1;
        if (m_k[d] > song_len[m_song[d]] * per) begin
          m_active[d]   = 1'b0;
          m_idle_idx[d] = song_len[m_song[d]] - 1;
        end
      end
      m_prev[d] = play_v[d];
    end
  endtask

  task automatic expect_out(input int d, output logic e_audio, output logic e_play,
                            output logic e_stop, output logic [2:0] e_idx);
    int per, note, off, code;
    e_audio = 1'b0; e_play = 1'b0; e_stop = 1'b0; e_idx = 3'(m_idle_idx[d]);
    if (m_active[d]) begin
      per = int'(note_cyc[d] + gap_cyc[d]);
      if (m_k[d] == song_len[m_song[d]] * per) begin
        e_stop = 1'b1;
        e_idx  = 3'(song_len[m_song[d]] - 1);
      end else begin
        note   = m_k[d] / per;
        off    = m_k[d] % per;
        code   = song_codes[m_song[d]][note];
        e_play = 1'b1;
        e_idx  = 3'(note);
        if (off < int'(note_cyc[d]) && code != 0) begin
          e_audio = ((off / half_tab[code]) % 2) == 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input int d, input logic [2:0] obs, input logic [2:0] exp_v);
    total = total + 1;
    assert (obs === exp_v) passed = passed + 1;
    else $error("FAIL %s dut%0d k=%0d observed=%0d expected=%0d", tag, d, m_k[d], obs, exp_v);
  endtask

  task automatic check_dut(input int d);
    logic ea, ep, es;
    logic [2:0] ei;
    expect_out(d, ea, ep, es, ei);
    chk("audio",   d, {2'b00, audio_v[d]},   {2'b00, ea});
    chk("playing", d, {2'b00, playing_v[d]}, {2'b00, ep});
    chk("stop",    d, {2'b00, stop_v[d]},    {2'b00, es});
    chk("note_idx", d, idx_v[d], ei);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_tick(0);
      model_tick(1);
      @(negedge clk);
      check_dut(0);
      check_dut(1);
    end
  endtask

  // One-cycle rising edge on i_play with the given song select.
  task automatic pulse(input int d, input logic [1:0] ind);
    ind_v[d]  = ind;
    play_v[d] = 1'b1;
    step(1);
    play_v[d] = 1'b0;
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst_n_v  = 2'b00;
    play_v   = 2'b00;
    ind_v[0] = 2'd0;
    ind_v[1] = 2'd0;
    model_reset(0);
    model_reset(1);

    // Reset state.
    step(3);
    rst_n_v = 2'b11;
    step(2);

    // Song 1 with i_play held high: one pass, one stop pulse, no retrigger.
    ind_v[0]  = 2'd1;
    play_v[0] = 1'b1;
    step(255);
    play_v[0] = 1'b0;
    step(40);

    // Random songs played to completion.
    for (int i = 0; i < 4; i++) begin
      pulse(0, 2'($urandom_range(0, 3)));
      step(8 * 60 + 5);
    end

    // Restart with song 3 during note 2 of song 2.
    pulse(0, 2'd2);
    step(2 * 60 + 20);
    pulse(0, 2'd3);
    step(4 * 60 + 10);

    // New rising edge in the very cycle the final gap of song 1 ends.
    pulse(0, 2'd1);
    step(4 * 60 - 1);
    pulse(0, 2'($urandom_range(0, 3)));
    step(8 * 60 + 5);

    // Asynchronous reset mid-note, then stay idle after release.
    pulse(0, 2'd0);
    step(70);
    #2;
    rst_n_v[0] = 1'b0;
    #1;
    model_reset(0);
    check_dut(0);
    step(3);
    rst_n_v[0] = 1'b1;
    step(20);

    // Restarts at random points.
    for (int i = 0; i < 6; i++) begin
      pulse(0, 2'($urandom_range(0, 3)));
      step($urandom_range(10, 400));
    end
    step(500);

    // Tone instance: song 1 note 0 (C6) and the rest note after it.
    pulse(1, 2'd1);
    step(25000);
    // Song 3 restart: first note G5.
    pulse(1, 2'd3);
    step(24005);
    // Song 0 restart: first note E5, first toggle at 18960.
    pulse(1, 2'd0);
    step(20000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
